pointwise_conv2: RTL

- 1x1 pointwise convolution stage that consumes the 32-channel, 14x16 feature map written by the preceding depthwise 3x3 stage.
- Produces OUT_CHANNELS feature maps. Each output is a bias plus a dot product over all input channels at the same pixel, followed by arithmetic shift, saturation and optional ReLU.
- Reads input, weight and bias memories through external 1-cycle-latency read ports and writes results through an external write port.
- Started by a start pulse; reports completion with a done pulse.

---
 rtl/pointwise_conv2.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pointwise_conv2.sv
// 1x1 pointwise convolution: per output word, a bias plus a dot product over all
// input channels at one pixel, then arithmetic shift, saturation and optional ReLU.
module pointwise_conv2 #(
  parameter int IN_CHANNELS  = 32,
  parameter int OUT_CHANNELS = 64,
  parameter int HEIGHT       = 14,
  parameter int WIDTH        = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int ACC_WIDTH    = 40,
  parameter int FRAC_BITS    = 8,
  parameter int RELU_EN      = 1,
  localparam int PIX   = HEIGHT * WIDTH,
  localparam int IN_AW = $clog2(IN_CHANNELS * PIX),
  localparam int W_AW  = $clog2(OUT_CHANNELS * IN_CHANNELS),
  localparam int B_AW  = $clog2(OUT_CHANNELS),
  localparam int O_AW  = $clog2(OUT_CHANNELS * PIX)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  in_en,
  output logic [IN_AW-1:0]      in_addr,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  w_en,
  output logic [W_AW-1:0]       w_addr,
  input  logic [DATA_WIDTH-1:0] w_dout,
  output logic                  b_en,
  output logic [B_AW-1:0]       b_addr,
  input  logic [DATA_WIDTH-1:0] b_dout,
  output logic                  out_we,
  output logic [O_AW-1:0]       out_addr,
  output logic [DATA_WIDTH-1:0] out_din
);

  localparam int OC_W  = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
  localparam int PIX_W = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int IC_W  = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;

  typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, WRITE, DONE} state_t;

  state_t                       state_reg, state_next;
  logic [OC_W-1:0]              oc_reg, oc_next;
  logic [PIX_W-1:0]             pix_reg, pix_next;
  logic [IC_W-1:0]              ic_reg, ic_next;
  logic signed [ACC_WIDTH-1:0]  acc_reg, acc_next;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    bias_ext;
  logic signed [ACC_WIDTH-1:0]    acc_shifted;
  logic [ACC_WIDTH-DATA_WIDTH:0]  top_bits;
  logic                           fits;
  logic [DATA_WIDTH-1:0]          sat_val;
  logic [DATA_WIDTH-1:0]          res_val;
  logic                           last_pix, last_oc, last_ic;

  assign prod        = $signed(in_dout) * $signed(w_dout);
  assign prod_ext    = ACC_WIDTH'(prod);
  assign bias_ext    = ACC_WIDTH'($signed(b_dout)) <<< FRAC_BITS;
  assign acc_shifted = acc_reg >>> FRAC_BITS;

  // The shifted value fits the output word iff all bits from the output sign bit up agree.
  assign top_bits = acc_shifted[ACC_WIDTH-1:DATA_WIDTH-1];
  assign fits     = (&top_bits) | ~(|top_bits);

  always_comb begin
    sat_val = acc_shifted[DATA_WIDTH-1:0];
    if (!fits)
      sat_val = acc_shifted[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    res_val = sat_val;
    if (RELU_EN != 0 && sat_val[DATA_WIDTH-1])
      res_val = '0;
  end

  assign last_pix = (pix_reg == PIX_W'(PIX - 1));
  assign last_oc  = (oc_reg == OC_W'(OUT_CHANNELS - 1));
  assign last_ic  = (ic_reg == IC_W'(IN_CHANNELS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      oc_reg    <= '0;
      pix_reg   <= '0;
      ic_reg    <= '0;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      oc_reg    <= oc_next;
      pix_reg   <= pix_next;
      ic_reg    <= ic_next;
      acc_reg   <= acc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    oc_next    = oc_reg;
    pix_next   = pix_reg;
    ic_next    = ic_reg;
    acc_next   = acc_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = BIAS;
          oc_next    = '0;
          pix_next   = '0;
          ic_next    = '0;
        end
      end
      BIAS: begin
        ic_next    = '0;
        state_next = MAC;
      end
      MAC: begin
        // Read data lags the address by one cycle: slot 0 sees the bias word.
        if (ic_reg == '0) acc_next = bias_ext;
        else              acc_next = acc_reg + prod_ext;
        if (last_ic) state_next = DRAIN;
        else         ic_next    = ic_reg + 1'b1;
      end
      DRAIN: begin
        acc_next   = acc_reg + prod_ext;
        state_next = WRITE;
      end
      WRITE: begin
        state_next = BIAS;
        if (last_pix) begin
          pix_next = '0;
          if (last_oc) state_next = DONE;
          else         oc_next    = oc_reg + 1'b1;
        end else begin
          pix_next = pix_reg + 1'b1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign in_en    = (state_reg == MAC);
  assign w_en     = (state_reg == MAC);
  assign b_en     = (state_reg == BIAS);
  assign out_we   = (state_reg == WRITE);
  assign in_addr  = IN_AW'(int'(ic_reg) * PIX + int'(pix_reg));
  assign w_addr   = W_AW'(int'(oc_reg) * IN_CHANNELS + int'(ic_reg));
  assign b_addr   = B_AW'(oc_reg);
  assign out_addr = O_AW'(int'(oc_reg) * PIX + int'(pix_reg));
  assign out_din  = res_val;

endmodule
